cache_mem_arbiter: RTL

//  Sits directly below the icache and dcache: arbitrates their single-word RAM requests onto one RAM port.

---
 rtl/cache_mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache single-word RAM requests onto one RAM port.
// dcache has priority; a starvation counter forces an icache grant after a run of dcache words.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DGNT = 2'd1;
  localparam logic [1:0] IGNT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

  logic [1:0]      state_reg, state_next;
  logic [CNTW-1:0] starve_cnt_reg, starve_cnt_next;
  logic            dreq;

  assign dreq = dREN | dWEN;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = 32'd0;
    ramstore        = 32'd0;
    dwait           = 1'b1;
    dload           = 32'd0;
    iwait           = 1'b1;
    iload           = 32'd0;

    case (state_reg)
      IDLE: begin
        if (dreq && iREN && starve_cnt_reg == LIMIT) begin
          state_next = IGNT;
        end else if (dreq) begin
          state_next = DGNT;
        end else if (iREN) begin
          state_next = IGNT;
        end
      end

      DGNT: begin
        // Address and data pass straight through; the dcache holds them stable until dwait drops.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_next = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait      = 1'b0;
          dload      = dWEN ? 32'd0 : ramload;
          state_next = IDLE;
          if (!iREN) begin
            starve_cnt_next = '0;
          end else if (starve_cnt_reg != LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
          end
        end
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_next = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait           = 1'b0;
          iload           = ramload;
          state_next      = IDLE;
          starve_cnt_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule
